// File: rtl/alu_exec_ctrl_if.sv
// Instruction issue/retire bus between the front end and alu_exec_ctrl.
// The master presents instructions; the slave (the sequencer) signals ready, done and err.
interface alu_exec_ctrl_if #(
  parameter int unsigned WIDTH_CONTROL = 4,
  parameter int unsigned REG_ADDR_W    = 4,
  parameter int unsigned IMM_W         = 8
);
  logic                     instr_valid;
  logic                     instr_ready;
  logic [WIDTH_CONTROL-1:0] instr_op;
  logic [REG_ADDR_W-1:0]    instr_rdest;
  logic [REG_ADDR_W-1:0]    instr_rsrc;
  logic                     instr_imm_en;
  logic [IMM_W-1:0]         instr_imm;
  logic                     instr_use_carry;
  logic                     done;
  logic                     err;

  modport master (
    output instr_valid, instr_op, instr_rdest, instr_rsrc,
           instr_imm_en, instr_imm, instr_use_carry,
    input  instr_ready, done, err
  );

  modport slave (
    input  instr_valid, instr_op, instr_rdest, instr_rsrc,
           instr_imm_en, instr_imm, instr_use_carry,
    output instr_ready, done, err
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback sequencer around the 16-bit ALU: register file, operand
// fetch, ALU drive, result/flag capture, writeback and PSR ({C,L,F,N,Z}).
module alu_exec_ctrl #(
  parameter int unsigned WIDTH_DATA    = 16,
  parameter int unsigned WIDTH_CONTROL = 4,
  parameter int unsigned REG_ADDR_W    = 4,
  parameter int unsigned IMM_W         = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  alu_exec_ctrl_if.slave           instr_bus,
  output logic [WIDTH_DATA-1:0]    alu_a,
  output logic [WIDTH_DATA-1:0]    alu_b,
  output logic [WIDTH_CONTROL-1:0] alu_control,
  output logic                     alu_carry_in,
  input  logic [WIDTH_DATA-1:0]    alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_low,
  input  logic                     alu_over,
  input  logic                     alu_neg,
  input  logic                     alu_zero,
  output logic [4:0]               psr,
  input  logic [REG_ADDR_W-1:0]    dbg_addr,
  output logic [WIDTH_DATA-1:0]    dbg_data
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef enum logic [WIDTH_CONTROL-1:0] {
    OP_ADD  = WIDTH_CONTROL'(0),
    OP_ADDU = WIDTH_CONTROL'(1),
    OP_SUB  = WIDTH_CONTROL'(2),
    OP_SUBU = WIDTH_CONTROL'(3),
    OP_CMP  = WIDTH_CONTROL'(4),
    OP_AND  = WIDTH_CONTROL'(5),
    OP_OR   = WIDTH_CONTROL'(6),
    OP_XOR  = WIDTH_CONTROL'(7),
    OP_LSH  = WIDTH_CONTROL'(8)
  } op_t;

  state_t                   state, state_next;
  logic [WIDTH_CONTROL-1:0] op_q;
  logic [REG_ADDR_W-1:0]    rdest_q;
  logic [REG_ADDR_W-1:0]    rsrc_q;
  logic                     imm_en_q;
  logic [IMM_W-1:0]         imm_q;
  logic                     use_carry_q;
  logic [WIDTH_DATA-1:0]    res_q;
  logic [4:0]               flag_q;
  logic [WIDTH_DATA-1:0]    rf [NUM_REGS];
  logic                     legal;
  logic                     ready_c, done_c, err_c;

  assign legal    = (op_q <= OP_LSH);
  assign dbg_data = rf[dbg_addr];

  assign instr_bus.instr_ready = ready_c;
  assign instr_bus.done        = done_c;
  assign instr_bus.err         = err_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    done_c     = 1'b0;
    err_c      = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (instr_bus.instr_valid) state_next = READ;
      end
      READ: state_next = EXEC;
      EXEC: state_next = WB;
      WB: begin
        done_c     = 1'b1;
        err_c      = ~legal;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The alu_* outputs double as the latched operand registers, so they
  // naturally hold their last value outside EXEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q         <= '0;
      rdest_q      <= '0;
      rsrc_q       <= '0;
      imm_en_q     <= 1'b0;
      imm_q        <= '0;
      use_carry_q  <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_control  <= '0;
      alu_carry_in <= 1'b0;
      res_q        <= '0;
      flag_q       <= '0;
      psr          <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) rf[REG_ADDR_W'(i)] <= '0;
    end else begin
      case (state)
        IDLE: if (instr_bus.instr_valid) begin
          op_q        <= instr_bus.instr_op;
          rdest_q     <= instr_bus.instr_rdest;
          rsrc_q      <= instr_bus.instr_rsrc;
          imm_en_q    <= instr_bus.instr_imm_en;
          imm_q       <= instr_bus.instr_imm;
          use_carry_q <= instr_bus.instr_use_carry;
        end
        READ: begin
          alu_a        <= rf[rdest_q];
          alu_b        <= imm_en_q ? {{(WIDTH_DATA-IMM_W){imm_q[IMM_W-1]}}, imm_q}
                                   : rf[rsrc_q];
          alu_control  <= op_q;
          alu_carry_in <= use_carry_q & psr[4];
        end
        EXEC: begin
          res_q  <= alu_result;
          flag_q <= {alu_carry, alu_low, alu_over, alu_neg, alu_zero};
        end
        WB: begin
          if (legal && op_q != OP_CMP) rf[rdest_q] <= res_q;
          case (op_q)
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU:
              psr <= {flag_q[4], psr[3], flag_q[2], flag_q[1:0]};
            OP_CMP:
              psr <= {psr[4], flag_q[3], psr[2], flag_q[1:0]};
            OP_AND, OP_OR, OP_XOR, OP_LSH:
              psr <= {psr[4:2], flag_q[1:0]};
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU on the alu_* pins, plus a
// register-file/PSR reference model driven by directed and random instructions.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] alu_a, alu_b, alu_result, dbg_data;
  logic [3:0]  alu_control, dbg_addr;
  logic        alu_carry_in, alu_carry, alu_low, alu_over, alu_neg, alu_zero;
  logic [4:0]  psr;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [15:0] ref_rf [16];
  logic [4:0]  ref_psr;
  logic [15:0] exp_a, exp_b;
  logic [3:0]  exp_ctl;
  logic        exp_cin, exp_err;

  int          obs_wait, obs_lat;
  logic        obs_err, obs_cin, obs_busy_rdy;
  logic [15:0] obs_a, obs_b;
  logic [3:0]  obs_ctl;

  always #5 clk = ~clk;

  alu_exec_ctrl_if #(.WIDTH_CONTROL(4), .REG_ADDR_W(4), .IMM_W(8)) bus ();

  alu_exec_ctrl #(
    .WIDTH_DATA(16), .WIDTH_CONTROL(4), .REG_ADDR_W(4), .IMM_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .instr_bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_low(alu_low),
    .alu_over(alu_over), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .psr(psr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU; flags an op does not define are driven with
  // operand-dependent junk so that wrongly-updated PSR bits show up.
  function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic ci);
    logic [16:0] s;
    logic [15:0] r;
    logic c, l, f, n, z, g;
    g = ^(a ^ {b[14:0], b[15]});
    s = '0; r = '0; c = g; l = ~g; f = g;
    case (op)
      0, 1: begin
        s = {1'b0, a} + {1'b0, b} + {16'b0, ci};
        r = s[15:0]; c = s[16];
        f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2, 3: begin
        s = {1'b0, a} - {1'b0, b} - {16'b0, ci};
        r = s[15:0]; c = s[16];
        f = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4: begin r = a - b; l = (a < b); end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = a << b[3:0];
      default: r = a ^ 16'h5A5A;
    endcase
    n = r[15];
    z = (r == 16'h0);
    if (op == 4) begin n = ($signed(a) < $signed(b)); z = (a == b); end
    return {r, c, l, f, n, z};
  endfunction

  always_comb
    {alu_result, alu_carry, alu_low, alu_over, alu_neg, alu_zero} =
      alu_fn(alu_control, alu_a, alu_b, alu_carry_in);

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0;
    ref_psr = 5'h0;
  endtask

  // Architectural effect of one instruction on the reference state.
  task automatic ref_step(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                          input logic ie, input logic [7:0] imm, input logic uc);
    logic [20:0] o;
    logic [15:0] r;
    exp_a   = ref_rf[rd];
    exp_b   = ie ? {{8{imm[7]}}, imm} : ref_rf[rs];
    exp_ctl = op;
    exp_cin = uc & ref_psr[4];
    exp_err = (op > 4'd8);
    o = alu_fn(op, exp_a, exp_b, exp_cin);
    r = o[20:5];
    if (op <= 4'd3) begin
      ref_rf[rd] = r;
      ref_psr[4] = o[4]; ref_psr[2] = o[2]; ref_psr[1] = o[1]; ref_psr[0] = o[0];
    end else if (op == 4'd4) begin
      ref_psr[3] = o[3]; ref_psr[1] = o[1]; ref_psr[0] = o[0];
    end else if (op <= 4'd8) begin
      ref_rf[rd] = r;
      ref_psr[1] = o[1]; ref_psr[0] = o[0];
    end
  endtask

  // Issue one instruction and follow it to retirement, recording what was seen.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic ie, input logic [7:0] imm, input logic uc);
    obs_wait = 0;
    while (bus.instr_ready !== 1'b1 && obs_wait < 20) begin
      @(posedge clk); #1; obs_wait++;
    end
    bus.instr_valid = 1'b1; bus.instr_op = op; bus.instr_rdest = rd; bus.instr_rsrc = rs;
    bus.instr_imm_en = ie; bus.instr_imm = imm; bus.instr_use_carry = uc;
    @(posedge clk); #1;
    obs_busy_rdy = bus.instr_ready;
    bus.instr_op = 4'($urandom); bus.instr_rdest = 4'($urandom); bus.instr_rsrc = 4'($urandom);
    bus.instr_imm_en = 1'($urandom); bus.instr_imm = 8'($urandom); bus.instr_use_carry = 1'($urandom);
    obs_lat = 0; obs_err = 1'b0;
    obs_a = 'x; obs_b = 'x; obs_ctl = 'x; obs_cin = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.instr_valid = 1'b0;
        obs_a = alu_a; obs_b = alu_b; obs_ctl = alu_control; obs_cin = alu_carry_in;
      end
      if (bus.done === 1'b1) begin
        obs_lat = k; obs_err = bus.err;
        break;
      end
    end
    if (obs_lat != 0) begin @(posedge clk); #1; end
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                          input logic ie, input logic [7:0] imm, input logic uc);
    run_instr(op, rd, rs, ie, imm, uc);
    ref_step(op, rd, rs, ie, imm, uc);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rdest = '0; bus.instr_rsrc = '0;
    bus.instr_imm_en = 1'b0; bus.instr_imm = '0; bus.instr_use_carry = 1'b0;
    dbg_addr = '0;
    ref_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus.instr_ready); end
    n_vec++; if ({bus.done, bus.err} !== 2'b00) begin n_bad++; $display("FAIL rst_done_err: got %b want 00", {bus.done, bus.err}); end
    n_vec++; if (psr !== 5'h0) begin n_bad++; $display("FAIL rst_psr: got %b want 00000", psr); end
    n_vec++;
    if ({alu_a, alu_b, alu_control, alu_carry_in} !== 37'h0) begin
      n_bad++; $display("FAIL rst_alu: got a=%h b=%h ctl=%h cin=%b want all 0", alu_a, alu_b, alu_control, alu_carry_in);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      n_vec++; if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL rst_reg[%0d]: got %h want 0000", i, dbg_data); end
    end
  endtask

  task automatic test_load_imm();
    do_instr(4'd0, 4'd1, 4'd0, 1'b1, 8'd5, 1'b0);
    dbg_addr = 4'd1; #1;
    n_vec++; if (obs_lat != 2) begin n_bad++; $display("FAIL load_latency: got %0d want 2", obs_lat); end
    n_vec++; if (obs_busy_rdy !== 1'b0) begin n_bad++; $display("FAIL load_busy_ready: got %b want 0", obs_busy_rdy); end
    n_vec++; if (dbg_data !== 16'h0005) begin n_bad++; $display("FAIL load_r1: got %h want 0005", dbg_data); end
    n_vec++; if (psr[0] !== 1'b0) begin n_bad++; $display("FAIL load_z: got %b want 0", psr[0]); end
    n_vec++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready_back: got %b want 1", bus.instr_ready); end
    n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL load_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_addu_carry();
    do_instr(4'd0, 4'd2, 4'd0, 1'b1, 8'hFF, 1'b0);
    do_instr(4'd1, 4'd2, 4'd1, 1'b0, 8'h00, 1'b0);
    dbg_addr = 4'd2; #1;
    n_vec++; if (dbg_data !== 16'h0004) begin n_bad++; $display("FAIL addu_r2: got %h want 0004", dbg_data); end
    n_vec++; if (psr !== 5'b10000) begin n_bad++; $display("FAIL addu_psr: got %b want 10000", psr); end
  endtask

  task automatic test_overflow();
    do_instr(4'd0, 4'd3, 4'd0, 1'b1, 8'h7F, 1'b0);
    do_instr(4'd8, 4'd3, 4'd0, 1'b1, 8'd8, 1'b0);
    do_instr(4'd0, 4'd6, 4'd0, 1'b1, 8'h7F, 1'b0);
    do_instr(4'd8, 4'd6, 4'd0, 1'b1, 8'd1, 1'b0);
    do_instr(4'd0, 4'd6, 4'd0, 1'b1, 8'd1, 1'b0);
    do_instr(4'd6, 4'd3, 4'd6, 1'b0, 8'h00, 1'b0);
    dbg_addr = 4'd3; #1;
    n_vec++; if (dbg_data !== 16'h7FFF) begin n_bad++; $display("FAIL ovf_build_r3: got %h want 7fff", dbg_data); end
    do_instr(4'd0, 4'd3, 4'd0, 1'b1, 8'd1, 1'b0);
    #1;
    n_vec++; if (dbg_data !== 16'h8000) begin n_bad++; $display("FAIL ovf_r3: got %h want 8000", dbg_data); end
    n_vec++; if (psr !== 5'b00110) begin n_bad++; $display("FAIL ovf_psr: got %b want 00110", psr); end
  endtask

  task automatic test_cmp();
    do_instr(4'd4, 4'd0, 4'd1, 1'b0, 8'h00, 1'b0);
    dbg_addr = 4'd0; #1;
    n_vec++; if (dbg_data !== 16'h0000) begin n_bad++; $display("FAIL cmp_r0: got %h want 0000", dbg_data); end
    n_vec++; if (psr !== 5'b01110) begin n_bad++; $display("FAIL cmp_psr: got %b want 01110", psr); end
  endtask

  task automatic test_use_carry();
    do_instr(4'd0, 4'd5, 4'd0, 1'b1, 8'hFF, 1'b0);
    do_instr(4'd1, 4'd5, 4'd0, 1'b1, 8'h01, 1'b0);
    n_vec++; if (psr !== 5'b11001) begin n_bad++; $display("FAIL uc_setup_psr: got %b want 11001", psr); end
    do_instr(4'd1, 4'd4, 4'd0, 1'b1, 8'h00, 1'b1);
    dbg_addr = 4'd4; #1;
    n_vec++; if (obs_cin !== 1'b1) begin n_bad++; $display("FAIL uc_cin: got %b want 1", obs_cin); end
    n_vec++; if (dbg_data !== 16'h0001) begin n_bad++; $display("FAIL uc_r4: got %h want 0001", dbg_data); end
  endtask

  task automatic test_illegal();
    logic [15:0] snap [16];
    logic [4:0]  psr_snap;
    int          diffs;
    for (int i = 0; i < 16; i++) snap[i] = ref_rf[i];
    psr_snap = ref_psr;
    do_instr(4'hC, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0);
    n_vec++; if (obs_lat != 2) begin n_bad++; $display("FAIL ill_latency: got %0d want 2", obs_lat); end
    n_vec++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", obs_err); end
    n_vec++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL ill_err_pulse: got %b want 0", bus.err); end
    n_vec++; if (psr !== psr_snap) begin n_bad++; $display("FAIL ill_psr: got %b want %b", psr, psr_snap); end
    diffs = 0;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      if (dbg_data !== snap[i]) diffs++;
    end
    n_vec++; if (diffs != 0) begin n_bad++; $display("FAIL ill_regs: got %0d changed want 0", diffs); end
  endtask

  task automatic test_random();
    logic [3:0] op, rd, rs;
    logic       ie, uc;
    logic [7:0] imm;
    int         mism;
    for (int i = 0; i < 60; i++) begin
      op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      rd  = 4'($urandom); rs = 4'($urandom);
      ie  = 1'($urandom); uc = 1'($urandom); imm = 8'($urandom);
      do_instr(op, rd, rs, ie, imm, uc);
      dbg_addr = rd; #1;
      n_vec++; if (obs_lat != 2) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want 2", i, obs_lat); end
      n_vec++; if (obs_err !== exp_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, obs_err, exp_err); end
      n_vec++;
      if ({obs_a, obs_b, obs_ctl, obs_cin} !== {exp_a, exp_b, exp_ctl, exp_cin}) begin
        n_bad++;
        $display("FAIL rnd_alu_drive[%0d]: got a=%h b=%h ctl=%h cin=%b want a=%h b=%h ctl=%h cin=%b",
                 i, obs_a, obs_b, obs_ctl, obs_cin, exp_a, exp_b, exp_ctl, exp_cin);
      end
      n_vec++; if (dbg_data !== ref_rf[rd]) begin n_bad++; $display("FAIL rnd_rd[%0d]: got %h want %h", i, dbg_data, ref_rf[rd]); end
      n_vec++; if (psr !== ref_psr) begin n_bad++; $display("FAIL rnd_psr[%0d]: got %b want %b", i, psr, ref_psr); end
    end
    mism = 0;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      if (dbg_data !== ref_rf[i]) mism++;
    end
    n_vec++; if (mism != 0) begin n_bad++; $display("FAIL rnd_regfile: got %0d wrong regs want 0", mism); end
  endtask

  task automatic test_back_to_back();
    do_instr(4'd0, 4'd7, 4'd0, 1'b1, 8'd3, 1'b0);
    do_instr(4'd0, 4'd7, 4'd7, 1'b0, 8'h00, 1'b0);
    n_vec++; if (obs_wait != 0) begin n_bad++; $display("FAIL b2b_wait: got %0d want 0", obs_wait); end
    dbg_addr = 4'd7; #1;
    n_vec++; if (dbg_data !== 16'h0006) begin n_bad++; $display("FAIL b2b_r7: got %h want 0006", dbg_data); end
    do_instr(4'd7, 4'd7, 4'd1, 1'b0, 8'h00, 1'b0);
    #1;
    n_vec++; if (dbg_data !== ref_rf[7]) begin n_bad++; $display("FAIL b2b_xor: got %h want %h", dbg_data, ref_rf[7]); end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    int nz;
    do_instr(4'd0, 4'd1, 4'd0, 1'b1, 8'h35, 1'b0);
    bus.instr_valid = 1'b1; bus.instr_op = 4'd0; bus.instr_rdest = 4'd1;
    bus.instr_imm_en = 1'b1; bus.instr_imm = 8'd7; bus.instr_use_carry = 1'b0;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; #1;
    ref_reset();
    dbg_addr = 4'd1; #1;
    n_vec++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", bus.instr_ready); end
    n_vec++; if (psr !== 5'h0) begin n_bad++; $display("FAIL midrst_psr: got %b want 00000", psr); end
    n_vec++; if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL midrst_r1: got %h want 0000", dbg_data); end
    done_seen = 0;
    repeat (2) begin @(posedge clk); #1; if (bus.done === 1'b1) done_seen++; end
    @(negedge clk) reset_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (bus.done === 1'b1) done_seen++; end
    n_vec++; if (done_seen != 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
    nz = 0;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      if (dbg_data !== 16'h0) nz++;
    end
    n_vec++; if (nz != 0) begin n_bad++; $display("FAIL midrst_regs: got %0d nonzero want 0", nz); end
  endtask

  initial begin
    test_reset();
    test_load_imm();
    test_addu_carry();
    test_overflow();
    test_cmp();
    test_use_carry();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
